rtc_set_ctrl: RTL and testbench
===============================

Name: rtc_set_ctrl

Overview:
Time-set controller for the BCD real-time clock counter chain. It takes two debounced user buttons and walks an edit state machine over hours, minutes and seconds in a shadow register. On commit it loads the shadow value into the clock counters with a one-cycle load pulse. While editing it halts the counters and drives a blink mask to the 7-segment digit drivers.

Parameters:
BLINK_DIV, 8, clock cycles per blink phase toggle (minimum 2)
TIMEOUT_CYC, 64, idle cycles in edit before abort (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
btn_mode  in  1  debounced level; rising edge advances the edit state
btn_inc  in  1  debounced level; rising edge increments the selected field
cur_hr  in  8  live hours, BCD {tens,units}
cur_min  in  8  live minutes, BCD
cur_sec  in  8  live seconds, BCD
run_en  out  1  counter chain enable; 0 while editing
load  out  1  one-cycle pulse; counters take ld_* values
ld_hr  out  8  shadow hours, BCD
ld_min  out  8  shadow minutes, BCD
ld_sec  out  8  shadow seconds, BCD
blink_mask  out  6  per-digit blank {HR_M,HR_L,MIN_M,MIN_L,SEC_M,SEC_L}; 1 = blank
editing  out  1  1 in any EDIT_* state

Behaviour:
- Reset values: run_en=1, load=0, ld_*=8'h00, blink_mask=0, editing=0, state=RUN, blink counter and phase =0, edge registers =0.
- Edge detect: one register per button; event = btn & ~btn_q. A held button yields exactly one event.
- FSM states: RUN, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT.
- RUN: on a mode event, snapshot cur_* into ld_*, go to EDIT_HR, and drop run_en in the same edge. inc events are ignored.
- EDIT_HR -> EDIT_MIN -> EDIT_SEC -> COMMIT, each on a mode event.
- COMMIT lasts exactly 1 cycle:
  - load=1 during that cycle;
  - next state RUN, where run_en=1 again.
  - load and run_en are never both 1.
- inc event in EDIT_x increments that field in BCD, with updated ld_* visible the next cycle:
  - units 9 -> 0 with tens+1;
  - hours 23 -> 00, minutes and seconds 59 -> 00.
- Mode and inc events in the same cycle: mode wins; inc is dropped.
- Snapshot values are not range-checked. An out-of-range value such as 8'h61 saturates to 00 on the next inc, with the field treated as at its max.
- Blink:
  - free-running counter to BLINK_DIV-1, toggling the phase on wrap;
  - the counter is cleared on entry to EDIT_HR.
  - blink_mask = phase ? the selected field's 2 bits : 0. Mask is 0 in RUN and COMMIT.
- Reset mid-edit: returns to RUN next edge; shadow is discarded; no load pulse is issued.
- All outputs are registered.

Optional Feature:
- RTC_SET_TIMEOUT_EN defined:
  - idle counter cleared on any button event or on state change;
  - in EDIT_* it counts up;
  - at TIMEOUT_CYC it aborts to RUN with run_en=1 and no load pulse, so the live time is kept.
- Undefined: no idle counter; edit mode persists indefinitely.

Decomposition:
- Package rtc_pkg:
  - state enum rtc_set_state_t;
  - field-max constants HR_MAX=8'h23, MIN_MAX=8'h59, SEC_MAX=8'h59;
  - blink_mask bit index constants.
- Sub-module bcd2_inc, combinational. Inputs: 8-bit BCD value and 8-bit max. Output: the next value with wrap or saturation. It is instantiated once, muxed by the selected field.

Test Plan:
1. Reset, then cur=12:34:56. Mode event -> editing=1, run_en=0, ld=12:34:56 next cycle; three more mode events -> exactly one load pulse with ld=12:34:56, then run_en=1.
2. In EDIT_HR with ld_hr=8'h22, two inc events -> 8'h23 then 8'h00; ld_min and ld_sec unchanged.
3. In EDIT_MIN with ld_min=8'h09, inc -> 8'h10; from 8'h59, inc -> 8'h00. In EDIT_SEC, btn_inc held 20 cycles -> single increment.
4. Mode and inc rising in the same cycle in EDIT_HR -> state EDIT_MIN, ld_hr unchanged. Reset asserted in EDIT_SEC -> RUN, run_en=1, load never pulses.
5. BLINK_DIV=8 in EDIT_MIN -> blink_mask alternates 6'b000000 / 6'b001100 every 8 cycles; 0 in RUN.
6. With RTC_SET_TIMEOUT_EN and TIMEOUT_CYC=64: enter edit, idle 64 cycles -> RUN, run_en=1, no load. An inc at cycle 40 restarts the count.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-set controller.
//   rtc_set_state_t : edit state machine encoding
//   *_MAX           : BCD field limits (hours 23, minutes/seconds 59)
//   BM_*            : bit positions in the 6-bit digit blink mask
package rtc_pkg;

    localparam int unsigned BCD_W = 8;
    localparam int unsigned BM_W  = 6;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_EDIT_HR  = 3'd1,
        ST_EDIT_MIN = 3'd2,
        ST_EDIT_SEC = 3'd3,
        ST_COMMIT   = 3'd4
    } rtc_set_state_t;

    localparam logic [BCD_W-1:0] HR_MAX  = 8'h23;
    localparam logic [BCD_W-1:0] MIN_MAX = 8'h59;
    localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;

    localparam int unsigned BM_HR_M  = 5;
    localparam int unsigned BM_HR_L  = 4;
    localparam int unsigned BM_MIN_M = 3;
    localparam int unsigned BM_MIN_L = 2;
    localparam int unsigned BM_SEC_M = 1;
    localparam int unsigned BM_SEC_L = 0;

    // Digits belonging to the field edited in state s; zero outside edit.
    function automatic logic [BM_W-1:0] field_mask(input rtc_set_state_t s);
        logic [BM_W-1:0] m;
        m = '0;
        case (s)
            ST_EDIT_HR: begin
                m[BM_HR_M] = 1'b1;
                m[BM_HR_L] = 1'b1;
            end
            ST_EDIT_MIN: begin
                m[BM_MIN_M] = 1'b1;
                m[BM_MIN_L] = 1'b1;
            end
            ST_EDIT_SEC: begin
                m[BM_SEC_M] = 1'b1;
                m[BM_SEC_L] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD increment with wrap at a field maximum.
// Ports:
//   val_i  : current BCD value {tens,units}
//   max_i  : field maximum in BCD (e.g. 8'h23, 8'h59)
//   nxt_c  : combinational next value; any value at or above max_i
//            (including out-of-range snapshots) becomes 8'h00
module bcd2_inc
    import rtc_pkg::*;
(
    input  logic [BCD_W-1:0] val_i,
    input  logic [BCD_W-1:0] max_i,
    output logic [BCD_W-1:0] nxt_c
);

    // Binary compare is valid for BCD operands with legal digits.
    always_comb begin
        nxt_c = '0;
        if (val_i >= max_i) begin
            nxt_c = '0;
        end else if (val_i[3:0] >= 4'd9) begin
            nxt_c = {val_i[7:4] + 4'd1, 4'd0};
        end else begin
            nxt_c = {val_i[7:4], val_i[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/rtc_set_ctrl.sv
// Time-set controller for the BCD RTC counter chain.
// Walks RUN -> EDIT_HR -> EDIT_MIN -> EDIT_SEC -> COMMIT -> RUN on btn_mode
// rising edges, edits a shadow copy of the time with btn_inc, and loads it
// into the counters with a one-cycle pulse on commit.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   btn_mode, btn_inc   : debounced button levels
//   cur_hr/min/sec      : live BCD time, snapshotted on edit entry
//   run_en              : counter enable, low while editing or committing
//   load                : one-cycle load strobe in COMMIT
//   ld_hr/min/sec       : shadow BCD time
//   blink_mask          : per-digit blank {HR_M,HR_L,MIN_M,MIN_L,SEC_M,SEC_L}
//   editing             : high in any EDIT_* state
// Build option: define RTC_SET_TIMEOUT_EN to abort an idle edit after
// TIMEOUT_CYC cycles without a button event.
module rtc_set_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned BLINK_DIV   = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic [BCD_W-1:0] cur_hr,
    input  logic [BCD_W-1:0] cur_min,
    input  logic [BCD_W-1:0] cur_sec,
    output logic             run_en,
    output logic             load,
    output logic [BCD_W-1:0] ld_hr,
    output logic [BCD_W-1:0] ld_min,
    output logic [BCD_W-1:0] ld_sec,
    output logic [BM_W-1:0]  blink_mask,
    output logic             editing
);

    localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("BLINK_DIV must be at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cyc
        $error("TIMEOUT_CYC must be at least 1");
    end

    rtc_set_state_t     state_q, state_d;
    logic               btn_mode_q, btn_mode_d;
    logic               btn_inc_q, btn_inc_d;
    logic [BCD_W-1:0]   ld_hr_q, ld_hr_d, ld_min_q, ld_min_d, ld_sec_q, ld_sec_d;
    logic               run_en_q, run_en_d, load_q, load_d, editing_q, editing_d;
    logic [BM_W-1:0]    blink_mask_q, blink_mask_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               mode_ev_c, inc_ev_c, in_edit_c;
    logic [BCD_W-1:0]   fld_val_c, fld_max_c, fld_nxt_c;

`ifdef RTC_SET_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    assign mode_ev_c = btn_mode & ~btn_mode_q;
    assign inc_ev_c  = btn_inc & ~btn_inc_q;
    assign in_edit_c = state_q inside {ST_EDIT_HR, ST_EDIT_MIN, ST_EDIT_SEC};

    // Select the field being edited for the shared incrementer.
    always_comb begin
        fld_val_c = ld_sec_q;
        fld_max_c = SEC_MAX;
        case (state_q)
            ST_EDIT_HR: begin
                fld_val_c = ld_hr_q;
                fld_max_c = HR_MAX;
            end
            ST_EDIT_MIN: begin
                fld_val_c = ld_min_q;
                fld_max_c = MIN_MAX;
            end
            default: ;
        endcase
    end

    bcd2_inc u_inc (
        .val_i (fld_val_c),
        .max_i (fld_max_c),
        .nxt_c (fld_nxt_c)
    );

    // Next state, shadow registers, blink timer and registered outputs.
    always_comb begin
        state_d     = state_q;
        btn_mode_d  = btn_mode;
        btn_inc_d   = btn_inc;
        ld_hr_d     = ld_hr_q;
        ld_min_d    = ld_min_q;
        ld_sec_d    = ld_sec_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        // A mode event always takes priority over a simultaneous inc event.
        case (state_q)
            ST_RUN: begin
                if (mode_ev_c) begin
                    state_d  = ST_EDIT_HR;
                    ld_hr_d  = cur_hr;
                    ld_min_d = cur_min;
                    ld_sec_d = cur_sec;
                end
            end
            ST_EDIT_HR: begin
                if (mode_ev_c)     state_d = ST_EDIT_MIN;
                else if (inc_ev_c) ld_hr_d = fld_nxt_c;
            end
            ST_EDIT_MIN: begin
                if (mode_ev_c)     state_d  = ST_EDIT_SEC;
                else if (inc_ev_c) ld_min_d = fld_nxt_c;
            end
            ST_EDIT_SEC: begin
                if (mode_ev_c)     state_d  = ST_COMMIT;
                else if (inc_ev_c) ld_sec_d = fld_nxt_c;
            end
            default: state_d = ST_RUN;
        endcase

`ifdef RTC_SET_TIMEOUT_EN
        // Abort an idle edit; shadow is untouched and no load is issued.
        if (in_edit_c && !mode_ev_c && !inc_ev_c && idle_q == IDLE_LAST) begin
            state_d = ST_RUN;
        end
        idle_d = idle_q;
        if (mode_ev_c || inc_ev_c || state_d != state_q) idle_d = '0;
        else if (in_edit_c)                              idle_d = idle_q + IDLE_W'(1);
`endif

        // Blink phase restarts its count on every edit entry.
        if (state_q == ST_RUN && state_d == ST_EDIT_HR) begin
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end

        run_en_d     = (state_d == ST_RUN);
        load_d       = (state_d == ST_COMMIT);
        editing_d    = state_d inside {ST_EDIT_HR, ST_EDIT_MIN, ST_EDIT_SEC};
        blink_mask_d = phase_d ? field_mask(state_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            btn_mode_q   <= 1'b0;
            btn_inc_q    <= 1'b0;
            ld_hr_q      <= '0;
            ld_min_q     <= '0;
            ld_sec_q     <= '0;
            run_en_q     <= 1'b1;
            load_q       <= 1'b0;
            editing_q    <= 1'b0;
            blink_mask_q <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
`ifdef RTC_SET_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            btn_mode_q   <= btn_mode_d;
            btn_inc_q    <= btn_inc_d;
            ld_hr_q      <= ld_hr_d;
            ld_min_q     <= ld_min_d;
            ld_sec_q     <= ld_sec_d;
            run_en_q     <= run_en_d;
            load_q       <= load_d;
            editing_q    <= editing_d;
            blink_mask_q <= blink_mask_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
`ifdef RTC_SET_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end

    assign run_en     = run_en_q;
    assign load       = load_q;
    assign ld_hr      = ld_hr_q;
    assign ld_min     = ld_min_q;
    assign ld_sec     = ld_sec_q;
    assign blink_mask = blink_mask_q;
    assign editing    = editing_q;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Self-checking bench for rtc_set_ctrl: directed scenarios plus a randomized
// run, all checked against a decimal-arithmetic reference of the set flow.
module tb_rtc_set_ctrl;

    localparam int BLINK_DIV   = 8;
    localparam int TIMEOUT_CYC = 64;
    localparam int S_RUN = 0, S_HR = 1, S_MIN = 2, S_SEC = 3, S_COMMIT = 4;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_inc;
    logic [7:0] cur_hr, cur_min, cur_sec;
    logic       run_en, load, editing;
    logic [7:0] ld_hr, ld_min, ld_sec;
    logic [5:0] blink_mask;

    int n_cmp  = 0;
    int n_fail = 0;
    int g_loads, g_both;

    // Reference state
    int         m_state;
    logic [7:0] m_hr, m_min, m_sec;
    logic       m_bm, m_bi;
    int         m_bcnt;
    logic       m_phase;
`ifdef RTC_SET_TIMEOUT_EN
    int         m_idle;
`endif

    always #5 clk = ~clk;

    rtc_set_ctrl #(.BLINK_DIV(BLINK_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
        .run_en(run_en), .load(load), .ld_hr(ld_hr), .ld_min(ld_min),
        .ld_sec(ld_sec), .blink_mask(blink_mask), .editing(editing)
    );

    // Decimal increment of a BCD field: at or above max wraps to zero.
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input int maxd);
        int d;
        d = int'(v[7:4]) * 10 + int'(v[3:0]);
        if (d >= maxd) return 8'h00;
        d = d + 1;
        return {4'(d / 10), 4'(d % 10)};
    endfunction

    function automatic void model_step();
        logic mev, iev;
        int   prev;
        if (rst) begin
            m_state = S_RUN; m_hr = 8'h00; m_min = 8'h00; m_sec = 8'h00;
            m_bm = 1'b0; m_bi = 1'b0; m_bcnt = 0; m_phase = 1'b0;
`ifdef RTC_SET_TIMEOUT_EN
            m_idle = 0;
`endif
            return;
        end
        mev  = btn_mode && !m_bm;
        iev  = btn_inc && !m_bi;
        m_bm = btn_mode;
        m_bi = btn_inc;
        prev = m_state;
        case (m_state)
            S_RUN: if (mev) begin
                m_hr = cur_hr; m_min = cur_min; m_sec = cur_sec; m_state = S_HR;
            end
            S_HR, S_MIN, S_SEC: begin
                if (mev) m_state = m_state + 1;
                else if (iev) begin
                    if (m_state == S_HR)       m_hr  = bcd_next(m_hr, 23);
                    else if (m_state == S_MIN) m_min = bcd_next(m_min, 59);
                    else                       m_sec = bcd_next(m_sec, 59);
                end
            end
            default: m_state = S_RUN;
        endcase
`ifdef RTC_SET_TIMEOUT_EN
        if (prev != m_state || mev || iev) m_idle = 0;
        else if (prev >= S_HR && prev <= S_SEC) begin
            m_idle = m_idle + 1;
            if (m_idle == TIMEOUT_CYC) begin m_state = S_RUN; m_idle = 0; end
        end
`endif
        if (prev == S_RUN && m_state == S_HR) m_bcnt = 0;
        else begin
            m_bcnt = m_bcnt + 1;
            if (m_bcnt == BLINK_DIV) begin m_bcnt = 0; m_phase = !m_phase; end
        end
    endfunction

    function automatic logic [5:0] exp_mask();
        if (m_phase && m_state >= S_HR && m_state <= S_SEC)
            return 6'(3 << (2 * (3 - m_state)));
        return 6'b0;
    endfunction

    // One clock: drive buttons, advance reference at the edge, settle, observe.
    task automatic tick(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        model_step();
        #1;
        g_loads += int'(load);
        g_both  += int'(load & run_en);
    endtask

    task automatic press_mode();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0);
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        cur_hr = h; cur_min = mi; cur_sec = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b0;
        n_cmp++; if (run_en !== 1'b1)  begin n_fail++; $display("FAIL reset_run_en: got %b want 1", run_en); end
        n_cmp++; if (load !== 1'b0)    begin n_fail++; $display("FAIL reset_load: got %b want 0", load); end
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL reset_editing: got %b want 0", editing); end
        n_cmp++; if (blink_mask !== 6'b0) begin n_fail++; $display("FAIL reset_mask: got %b want 0", blink_mask); end
        n_cmp++; if ({ld_hr, ld_min, ld_sec} !== 24'h0) begin n_fail++; $display("FAIL reset_ld: got %h want 000000", {ld_hr, ld_min, ld_sec}); end
    endtask

    task automatic test_set_sequence();
        logic [23:0] seen;
        do_reset();
        set_cur(8'h12, 8'h34, 8'h56);
        tick(1'b1, 1'b0);
        n_cmp++; if (editing !== 1'b1) begin n_fail++; $display("FAIL seq_editing: got %b want 1", editing); end
        n_cmp++; if (run_en !== 1'b0)  begin n_fail++; $display("FAIL seq_run_en_low: got %b want 0", run_en); end
        n_cmp++; if ({ld_hr, ld_min, ld_sec} !== 24'h123456) begin n_fail++; $display("FAIL seq_snapshot: got %h want 123456", {ld_hr, ld_min, ld_sec}); end
        tick(1'b0, 1'b0);
        set_cur(8'h01, 8'h02, 8'h03);
        g_loads = 0; g_both = 0; seen = 24'h0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0);
            if (load) seen = {ld_hr, ld_min, ld_sec};
            tick(1'b0, 1'b0);
        end
        tick(1'b0, 1'b0);
        n_cmp++; if (g_loads !== 1) begin n_fail++; $display("FAIL seq_load_count: got %0d want 1", g_loads); end
        n_cmp++; if (g_both !== 0)  begin n_fail++; $display("FAIL seq_load_and_run: got %0d want 0", g_both); end
        n_cmp++; if (seen !== 24'h123456) begin n_fail++; $display("FAIL seq_load_value: got %h want 123456", seen); end
        n_cmp++; if (run_en !== 1'b1 || editing !== 1'b0) begin n_fail++; $display("FAIL seq_back_to_run: got run_en=%b editing=%b want 1/0", run_en, editing); end
    endtask

    task automatic test_hr_wrap();
        do_reset();
        set_cur(8'h22, 8'h10, 8'h20);
        press_mode();
        tick(1'b0, 1'b1);
        n_cmp++; if (ld_hr !== 8'h23) begin n_fail++; $display("FAIL hr_inc_23: got %h want 23", ld_hr); end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        n_cmp++; if (ld_hr !== 8'h00) begin n_fail++; $display("FAIL hr_wrap_00: got %h want 00", ld_hr); end
        n_cmp++; if ({ld_min, ld_sec} !== 16'h1020) begin n_fail++; $display("FAIL hr_others_kept: got %h want 1020", {ld_min, ld_sec}); end
        press_mode(); press_mode(); press_mode();
    endtask

    task automatic test_min_sec();
        do_reset();
        set_cur(8'h05, 8'h09, 8'h30);
        press_mode(); press_mode();
        tick(1'b0, 1'b1);
        n_cmp++; if (ld_min !== 8'h10) begin n_fail++; $display("FAIL min_carry: got %h want 10", ld_min); end
        tick(1'b0, 1'b0);
        press_mode(); press_mode();
        set_cur(8'h05, 8'h59, 8'h30);
        press_mode(); press_mode();
        tick(1'b0, 1'b1);
        n_cmp++; if (ld_min !== 8'h00) begin n_fail++; $display("FAIL min_wrap: got %h want 00", ld_min); end
        tick(1'b0, 1'b0);
        press_mode();
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        n_cmp++; if (ld_sec !== 8'h31) begin n_fail++; $display("FAIL sec_held_single: got %h want 31", ld_sec); end
        press_mode();
        set_cur(8'h05, 8'h09, 8'h61);
        press_mode(); press_mode(); press_mode();
        tick(1'b0, 1'b1);
        n_cmp++; if (ld_sec !== 8'h00) begin n_fail++; $display("FAIL sec_out_of_range: got %h want 00", ld_sec); end
        press_mode(); tick(1'b0, 1'b0);
    endtask

    task automatic test_mode_inc_collision_and_reset();
        do_reset();
        set_cur(8'h07, 8'h15, 8'h45);
        press_mode();
        tick(1'b1, 1'b1);
        n_cmp++; if (ld_hr !== 8'h07 || editing !== 1'b1) begin n_fail++; $display("FAIL collide_hr_kept: got hr=%h ed=%b want 07/1", ld_hr, editing); end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        n_cmp++; if ({ld_hr, ld_min} !== 16'h0716) begin n_fail++; $display("FAIL collide_now_min: got %h want 0716", {ld_hr, ld_min}); end
        tick(1'b0, 1'b0);
        press_mode();
        g_loads = 0; g_both = 0;
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        n_cmp++; if (run_en !== 1'b1 || editing !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got run_en=%b ed=%b want 1/0", run_en, editing); end
        n_cmp++; if ({ld_hr, ld_min, ld_sec} !== 24'h0) begin n_fail++; $display("FAIL midreset_shadow: got %h want 000000", {ld_hr, ld_min, ld_sec}); end
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0);
        n_cmp++; if (g_loads !== 0) begin n_fail++; $display("FAIL midreset_no_load: got %0d want 0", g_loads); end
    endtask

    task automatic test_blink();
        int last, ones;
        do_reset();
        set_cur(8'h10, 8'h20, 8'h30);
        press_mode(); press_mode();
        last = -1; ones = 0;
        for (int c = 0; c < 48; c++) begin
            logic [5:0] prev_mask;
            prev_mask = blink_mask;
            tick(1'b0, 1'b0);
            n_cmp++; if (blink_mask !== exp_mask()) begin n_fail++; $display("FAIL blink_model cyc %0d: got %b want %b", c, blink_mask, exp_mask()); end
            n_cmp++; if (blink_mask !== 6'b000000 && blink_mask !== 6'b001100) begin n_fail++; $display("FAIL blink_pattern cyc %0d: got %b want 000000|001100", c, blink_mask); end
            if (blink_mask === 6'b001100) ones++;
            if (blink_mask !== prev_mask && c > 0) begin
                if (last >= 0) begin
                    n_cmp++; if (c - last !== BLINK_DIV) begin n_fail++; $display("FAIL blink_period: got %0d want %0d", c - last, BLINK_DIV); end
                end
                last = c;
            end
        end
        n_cmp++; if (ones !== 24) begin n_fail++; $display("FAIL blink_duty: got %0d want 24", ones); end
        press_mode(); press_mode();
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 1'b0);
            n_cmp++; if (blink_mask !== 6'b0) begin n_fail++; $display("FAIL blink_run_zero cyc %0d: got %b want 0", c, blink_mask); end
        end
    endtask

`ifdef RTC_SET_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        g_loads = 0;
        tick(1'b1, 1'b0);
        for (int k = 0; k < 63; k++) tick(1'b0, 1'b0);
        n_cmp++; if (editing !== 1'b1) begin n_fail++; $display("FAIL tmo_before: got %b want 1", editing); end
        tick(1'b0, 1'b0);
        n_cmp++; if (run_en !== 1'b1 || editing !== 1'b0) begin n_fail++; $display("FAIL tmo_abort: got run_en=%b ed=%b want 1/0", run_en, editing); end
        tick(1'b1, 1'b0);
        for (int k = 0; k < 39; k++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int k = 0; k < 63; k++) tick(1'b0, 1'b0);
        n_cmp++; if (editing !== 1'b1) begin n_fail++; $display("FAIL tmo_restart: got %b want 1", editing); end
        tick(1'b0, 1'b0);
        n_cmp++; if (run_en !== 1'b1 || editing !== 1'b0) begin n_fail++; $display("FAIL tmo_abort2: got run_en=%b ed=%b want 1/0", run_en, editing); end
        n_cmp++; if (g_loads !== 0) begin n_fail++; $display("FAIL tmo_no_load: got %0d want 0", g_loads); end
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        tick(1'b1, 1'b0);
        for (int k = 0; k < 200; k++) tick(1'b0, 1'b0);
        n_cmp++; if (editing !== 1'b1 || run_en !== 1'b0) begin n_fail++; $display("FAIL no_tmo_persist: got ed=%b run_en=%b want 1/0", editing, run_en); end
        press_mode(); press_mode(); press_mode();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0)
                set_cur({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                        {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                        {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            n_cmp++; if (run_en !== (m_state == S_RUN)) begin n_fail++; $display("FAIL rand_run_en cyc %0d: got %b want %b", c, run_en, m_state == S_RUN); end
            n_cmp++; if (load !== (m_state == S_COMMIT)) begin n_fail++; $display("FAIL rand_load cyc %0d: got %b want %b", c, load, m_state == S_COMMIT); end
            n_cmp++; if (editing !== (m_state >= S_HR && m_state <= S_SEC)) begin n_fail++; $display("FAIL rand_editing cyc %0d: got %b state %0d", c, editing, m_state); end
            n_cmp++; if (ld_hr !== m_hr)   begin n_fail++; $display("FAIL rand_ld_hr cyc %0d: got %h want %h", c, ld_hr, m_hr); end
            n_cmp++; if (ld_min !== m_min) begin n_fail++; $display("FAIL rand_ld_min cyc %0d: got %h want %h", c, ld_min, m_min); end
            n_cmp++; if (ld_sec !== m_sec) begin n_fail++; $display("FAIL rand_ld_sec cyc %0d: got %h want %h", c, ld_sec, m_sec); end
            n_cmp++; if (blink_mask !== exp_mask()) begin n_fail++; $display("FAIL rand_mask cyc %0d: got %b want %b", c, blink_mask, exp_mask()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        set_cur(8'h00, 8'h00, 8'h00);
        g_loads = 0; g_both = 0;
        test_reset();
        test_set_sequence();
        test_hr_wrap();
        test_min_sec();
        test_mode_inc_collision_and_reset();
        test_blink();
`ifdef RTC_SET_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
